// File: rtl/rv_mem_arb_if.sv
// Bus bundle between the IF/MEM pipeline stages, the arbiter and the unified memory.
// The arbiter takes the slave view; the requester/memory side takes the master view.
interface rv_mem_arb_if;
  logic        if_req_i;
  logic [63:0] if_addr_i;
  logic        if_gnt_o;
  logic        if_rvalid_o;
  logic [31:0] if_rdata_o;
  logic        d_req_i;
  logic        d_we_i;
  logic [63:0] d_addr_i;
  logic [63:0] d_wdata_i;
  logic        d_gnt_o;
  logic        d_rvalid_o;
  logic [63:0] d_rdata_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [63:0] mem_addr_o;
  logic [63:0] mem_wdata_o;
  logic [63:0] mem_rdata_i;
  logic        if_stall_o;
  logic        d_stall_o;

  modport slave (
    input  if_req_i, if_addr_i, d_req_i, d_we_i, d_addr_i, d_wdata_i, mem_rdata_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o, d_gnt_o, d_rvalid_o, d_rdata_o,
           mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, if_stall_o, d_stall_o
  );

  modport master (
    output if_req_i, if_addr_i, d_req_i, d_we_i, d_addr_i, d_wdata_i, mem_rdata_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o, d_gnt_o, d_rvalid_o, d_rdata_o,
           mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, if_stall_o, d_stall_o
  );
endinterface

// File: rtl/rv_mem_arb.sv
// Fixed-latency arbiter for the single-ported unified memory shared by IF and MEM.
// Data has priority; a streak counter forces a fetch grant after D_MAX data grants.
//
//   state | meaning
//   IDLE  | no access in flight; every cycle is an arbitration window
//   BUSY  | access in flight; lat_cnt==0 is the response cycle and also a window
module rv_mem_arb #(
  parameter int MEM_LAT = 2,
  parameter int D_MAX   = 3
) (
  input logic          clk,
  input logic          rst,
  rv_mem_arb_if.slave  bus
);

  typedef enum logic {IDLE, BUSY} state_t;
  typedef enum logic {OWN_IF, OWN_D} owner_t;

  localparam logic [2:0] LAT_INIT   = 3'(MEM_LAT - 1);
  localparam logic [2:0] STREAK_MAX = 3'(D_MAX);

  state_t     state, state_nxt;
  owner_t     owner, owner_nxt;
  logic [2:0] lat_cnt, lat_cnt_nxt;
  logic [2:0] d_streak, d_streak_nxt;
  logic       if_word_sel, if_word_sel_nxt;
  logic       d_we_q, d_we_q_nxt;

  logic       resp;
  logic       window;
  logic       gnt_if;
  logic       gnt_d;
  logic       unused_addr_bits;

  assign unused_addr_bits = ^{bus.d_addr_i[2:0], bus.if_addr_i[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      owner       <= OWN_IF;
      lat_cnt     <= 3'd0;
      d_streak    <= 3'd0;
      if_word_sel <= 1'b0;
      d_we_q      <= 1'b0;
    end else begin
      state       <= state_nxt;
      owner       <= owner_nxt;
      lat_cnt     <= lat_cnt_nxt;
      d_streak    <= d_streak_nxt;
      if_word_sel <= if_word_sel_nxt;
      d_we_q      <= d_we_q_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    owner_nxt       = owner;
    lat_cnt_nxt     = lat_cnt;
    d_streak_nxt    = d_streak;
    if_word_sel_nxt = if_word_sel;
    d_we_q_nxt      = d_we_q;

    // Gating with rst keeps every output quiet while reset is held.
    resp   = ~rst && (state == BUSY) && (lat_cnt == 3'd0);
    window = ~rst && ((state == IDLE) || resp);
    gnt_d  = window && bus.d_req_i && !(bus.if_req_i && (d_streak == STREAK_MAX));
    gnt_if = window && bus.if_req_i && !gnt_d;

    if (gnt_d || gnt_if) begin
      state_nxt   = BUSY;
      lat_cnt_nxt = LAT_INIT;
      owner_nxt   = gnt_d ? OWN_D : OWN_IF;
    end else if (window) begin
      state_nxt = IDLE;
    end else if (lat_cnt != 3'd0) begin
      lat_cnt_nxt = lat_cnt - 3'd1;
    end

    if (gnt_if) if_word_sel_nxt = bus.if_addr_i[2];
    if (gnt_d)  d_we_q_nxt      = bus.d_we_i;

    if (!bus.if_req_i || gnt_if) begin
      d_streak_nxt = 3'd0;
    end else if (gnt_d && (d_streak != STREAK_MAX)) begin
      d_streak_nxt = d_streak + 3'd1;
    end

    bus.if_gnt_o    = gnt_if;
    bus.d_gnt_o     = gnt_d;
    bus.mem_req_o   = gnt_if || gnt_d;
    bus.mem_we_o    = gnt_d && bus.d_we_i;
    bus.mem_addr_o  = 64'd0;
    if (gnt_d)       bus.mem_addr_o = {bus.d_addr_i[63:3], 3'b000};
    else if (gnt_if) bus.mem_addr_o = {bus.if_addr_i[63:3], 3'b000};
    bus.mem_wdata_o = (gnt_if || gnt_d) ? bus.d_wdata_i : 64'd0;

    bus.if_rvalid_o = resp && (owner == OWN_IF);
    bus.if_rdata_o  = 32'd0;
    if (bus.if_rvalid_o)
      bus.if_rdata_o = if_word_sel ? bus.mem_rdata_i[63:32] : bus.mem_rdata_i[31:0];

    bus.d_rvalid_o = resp && (owner == OWN_D);
    // Stores acknowledge on the same cycle a load would return, with zero data.
    bus.d_rdata_o  = (bus.d_rvalid_o && !d_we_q) ? bus.mem_rdata_i : 64'd0;

    bus.if_stall_o = ~rst && bus.if_req_i && !bus.if_rvalid_o;
    bus.d_stall_o  = ~rst && bus.d_req_i && !bus.d_rvalid_o;
  end

endmodule

// File: tb/tb_rv_mem_arb.sv
// Directed bench for rv_mem_arb: a vector table for single accesses plus
// hand sequences for the streak limit, mid-transaction reset and MEM_LAT=1.
module tb_rv_mem_arb;

  typedef struct packed {
    logic        if_req;
    logic [63:0] if_addr;
    logic        d_req;
    logic        d_we;
    logic [63:0] d_addr;
    logic [63:0] d_wdata;
    logic [63:0] mem_rdata;
  } in_t;

  typedef struct packed {
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [63:0] d_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        if_stall;
    logic        d_stall;
  } out_t;

  typedef struct {
    in_t  in;
    out_t exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  rv_mem_arb_if bus0 ();
  rv_mem_arb_if bus1 ();

  rv_mem_arb #(.MEM_LAT(2), .D_MAX(3)) u_dut  (.clk(clk), .rst(rst), .bus(bus0));
  rv_mem_arb #(.MEM_LAT(1), .D_MAX(3)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

  out_t out0, out1;
  assign out0 = {bus0.if_gnt_o, bus0.if_rvalid_o, bus0.if_rdata_o, bus0.d_gnt_o, bus0.d_rvalid_o,
                 bus0.d_rdata_o, bus0.mem_req_o, bus0.mem_we_o, bus0.mem_addr_o, bus0.mem_wdata_o,
                 bus0.if_stall_o, bus0.d_stall_o};
  assign out1 = {bus1.if_gnt_o, bus1.if_rvalid_o, bus1.if_rdata_o, bus1.d_gnt_o, bus1.d_rvalid_o,
                 bus1.d_rdata_o, bus1.mem_req_o, bus1.mem_we_o, bus1.mem_addr_o, bus1.mem_wdata_o,
                 bus1.if_stall_o, bus1.d_stall_o};

  task automatic drive0(input in_t v);
    bus0.if_req_i = v.if_req;  bus0.if_addr_i = v.if_addr;
    bus0.d_req_i  = v.d_req;   bus0.d_we_i    = v.d_we;
    bus0.d_addr_i = v.d_addr;  bus0.d_wdata_i = v.d_wdata;
    bus0.mem_rdata_i = v.mem_rdata;
  endtask

  task automatic drive1(input in_t v);
    bus1.if_req_i = v.if_req;  bus1.if_addr_i = v.if_addr;
    bus1.d_req_i  = v.d_req;   bus1.d_we_i    = v.d_we;
    bus1.d_addr_i = v.d_addr;  bus1.d_wdata_i = v.d_wdata;
    bus1.mem_rdata_i = v.mem_rdata;
  endtask

  task automatic check(input string name, input out_t got, input out_t exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  vec_t v[16];
  in_t  iv;
  out_t ev;

  initial begin
    foreach (v[i]) begin
      v[i].in  = '0;
      v[i].exp = '0;
    end
    // single fetch from 0x104: upper word returned two cycles later
    v[1].in.if_req = 1'b1;  v[1].in.if_addr = 64'h104;
    v[1].exp.if_gnt = 1'b1; v[1].exp.mem_req = 1'b1; v[1].exp.mem_addr = 64'h100; v[1].exp.if_stall = 1'b1;
    v[2].in.if_req = 1'b1;  v[2].in.if_addr = 64'h104; v[2].exp.if_stall = 1'b1;
    v[3].in.if_addr = 64'h104; v[3].in.mem_rdata = 64'hAAAA_BBBB_CCCC_DDDD;
    v[3].exp.if_rvalid = 1'b1; v[3].exp.if_rdata = 32'hAAAA_BBBB;
    // load and fetch together: load first, fetch granted on the load's response cycle
    v[5].in.if_req = 1'b1; v[5].in.if_addr = 64'h200; v[5].in.d_req = 1'b1; v[5].in.d_addr = 64'h3010;
    v[5].exp.d_gnt = 1'b1; v[5].exp.mem_req = 1'b1; v[5].exp.mem_addr = 64'h3010;
    v[5].exp.if_stall = 1'b1; v[5].exp.d_stall = 1'b1;
    v[6].in.if_req = 1'b1; v[6].in.if_addr = 64'h200; v[6].in.d_addr = 64'h3010; v[6].exp.if_stall = 1'b1;
    v[7].in.if_req = 1'b1; v[7].in.if_addr = 64'h200; v[7].in.mem_rdata = 64'h0123_4567_89AB_CDEF;
    v[7].exp.d_rvalid = 1'b1; v[7].exp.d_rdata = 64'h0123_4567_89AB_CDEF;
    v[7].exp.if_gnt = 1'b1; v[7].exp.mem_req = 1'b1; v[7].exp.mem_addr = 64'h200; v[7].exp.if_stall = 1'b1;
    v[8].in.if_addr = 64'h200;
    v[9].in.if_addr = 64'h200; v[9].in.mem_rdata = 64'hFEED_FACE_1234_5678;
    v[9].exp.if_rvalid = 1'b1; v[9].exp.if_rdata = 32'h1234_5678;
    // store to 0x2007: aligned address, write data passed through, ack with zero data
    v[10].in.d_req = 1'b1; v[10].in.d_we = 1'b1; v[10].in.d_addr = 64'h2007;
    v[10].in.d_wdata = 64'h1122_3344_5566_7788;
    v[10].exp.d_gnt = 1'b1; v[10].exp.mem_req = 1'b1; v[10].exp.mem_we = 1'b1;
    v[10].exp.mem_addr = 64'h2000; v[10].exp.mem_wdata = 64'h1122_3344_5566_7788; v[10].exp.d_stall = 1'b1;
    v[11].in.d_addr = 64'h2007;
    // store ack and a new load grant in the same cycle
    v[12].in.d_req = 1'b1; v[12].in.d_addr = 64'h48; v[12].in.mem_rdata = 64'hDEAD_BEEF_CAFE_F00D;
    v[12].exp.d_rvalid = 1'b1; v[12].exp.d_gnt = 1'b1; v[12].exp.mem_req = 1'b1; v[12].exp.mem_addr = 64'h48;
    v[13].in.d_addr = 64'h48;
    v[14].in.d_addr = 64'h48; v[14].in.mem_rdata = 64'h0BAD_C0DE_0BAD_C0DE;
    v[14].exp.d_rvalid = 1'b1; v[14].exp.d_rdata = 64'h0BAD_C0DE_0BAD_C0DE;

    // reset held with both requests high: everything must stay zero
    iv = '0; iv.if_req = 1'b1; iv.d_req = 1'b1; iv.d_addr = 64'h10;
    drive0(iv);
    drive1(iv);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_dut0", out0, '0);
    check("reset_dut1", out1, '0);
    drive0('0);
    drive1('0);
    next_cycle();
    rst = 1'b0;

    foreach (v[i]) begin
      drive0(v[i].in);
      @(negedge clk);
      check($sformatf("vec%0d", i), out0, v[i].exp);
      next_cycle();
    end

    // streak limit with both requesters held: D,D,D,IF repeating
    begin
      logic exp_d [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      int   n = 0;
      iv = '0; iv.if_req = 1'b1; iv.if_addr = 64'h400; iv.d_req = 1'b1; iv.d_addr = 64'h500;
      drive0(iv);
      for (int c = 0; c < 40 && n < 8; c++) begin
        @(negedge clk);
        if (out0.if_gnt || out0.d_gnt) begin
          check_val($sformatf("streak_grant%0d", n), {62'd0, out0.if_gnt, out0.d_gnt},
                    {62'd0, ~exp_d[n], exp_d[n]});
          n++;
        end
        next_cycle();
      end
      if (n < 8) check_val("streak_timeout", 64'(n), 64'd8);
      drive0('0);
      repeat (4) next_cycle();
    end

    // reset one cycle after a load grant: stale response discarded
    iv = '0; iv.d_req = 1'b1; iv.d_addr = 64'h600;
    drive0(iv);
    @(negedge clk);
    check_val("rst_load_gnt", {63'd0, out0.d_gnt}, 64'd1);
    next_cycle();
    rst = 1'b1;
    iv.if_req = 1'b1;
    drive0(iv);
    @(negedge clk);
    check("rst_mid_outputs", out0, '0);
    next_cycle();
    rst = 1'b0;
    iv = '0; iv.d_req = 1'b1; iv.d_addr = 64'h88;
    drive0(iv);
    @(negedge clk);
    ev = '0; ev.d_gnt = 1'b1; ev.mem_req = 1'b1; ev.mem_addr = 64'h88; ev.d_stall = 1'b1;
    check("rst_release_gnt", out0, ev);
    next_cycle();
    iv.d_req = 1'b0;
    drive0(iv);
    @(negedge clk);
    check("rst_release_wait", out0, '0);
    next_cycle();
    iv.mem_rdata = 64'h5A5A_5A5A_A5A5_A5A5;
    drive0(iv);
    @(negedge clk);
    ev = '0; ev.d_rvalid = 1'b1; ev.d_rdata = 64'h5A5A_5A5A_A5A5_A5A5;
    check("rst_release_resp", out0, ev);
    drive0('0);
    next_cycle();

    // MEM_LAT=1: alternate fetch/load every cycle, response the next cycle
    for (int k = 0; k <= 6; k++) begin
      iv = '0;
      iv.mem_rdata = 64'h1111_2222_3333_4444;
      ev = '0;
      if (k < 6) begin
        if (k % 2 == 0) begin
          iv.if_req = 1'b1; iv.if_addr = 64'h1004;
          ev.if_gnt = 1'b1; ev.mem_addr = 64'h1000;
        end else begin
          iv.d_req = 1'b1; iv.d_addr = 64'h2000 + 64'(k * 8);
          ev.d_gnt = 1'b1; ev.mem_addr = 64'h2000 + 64'(k * 8);
        end
        ev.mem_req = 1'b1;
      end
      if (k > 0) begin
        if (k % 2 == 1) begin
          ev.if_rvalid = 1'b1; ev.if_rdata = 32'h1111_2222;
        end else begin
          ev.d_rvalid = 1'b1; ev.d_rdata = 64'h1111_2222_3333_4444;
        end
      end
      ev.if_stall = iv.if_req && !ev.if_rvalid;
      ev.d_stall  = iv.d_req && !ev.d_rvalid;
      drive1(iv);
      @(negedge clk);
      check($sformatf("lat1_cycle%0d", k), out1, ev);
      next_cycle();
    end
    drive1('0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
